// File: rtl/rng_pkg.sv
// rng_pkg: shared types and default sizes for the RNG scheduler slice.
package rng_pkg;

  localparam int RNG_DATA_W  = 32;
  localparam int RNG_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2
  } rng_sched_state_t;

endpackage

// File: rtl/rng_word_fifo.sv
// rng_word_fifo: small synchronous prefetch FIFO for generator words.
// Flush has priority over push/pop. Push is ignored when full and pop when empty.
module rng_word_fifo #(
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [DATA_W-1:0]            din,
  output logic [DATA_W-1:0]            head,
  output logic [$clog2(BUF_DEPTH):0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int AW    = $clog2(BUF_DEPTH);
  localparam int LVL_W = AW + 1;

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LVL_W'(BUF_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Storage array: written on accepted push only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

endmodule

// File: rtl/rng_sched.sv
// rng_sched: seeds the shared RNG core, prefetches its words and grants them
// round-robin to NUM_REQ consumers.
// Optional build macro RNG_HEALTH_EN enables the repetition health test.
module rng_sched
  import rng_pkg::*;
#(
  parameter int NUM_REQ   = RNG_NUM_REQ,
  parameter int DATA_W    = RNG_DATA_W,
  parameter int BUF_DEPTH = 4
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        cfg_enable,
  input  logic                        cfg_seed_load,
  input  logic [DATA_W-1:0]           cfg_seed,
  output logic                        gen_seed_valid,
  output logic [DATA_W-1:0]           gen_seed,
  input  logic                        gen_seed_ack,
  input  logic                        gen_valid,
  input  logic [DATA_W-1:0]           gen_data,
  output logic                        gen_ready,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]           gnt_data,
  output logic [$clog2(BUF_DEPTH):0]  buf_level,
  output logic                        busy,
  output logic                        health_fail
);

  localparam int PTR_W = $clog2(NUM_REQ);

  rng_sched_state_t   state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic               win_found;
  logic               grant_go;
  logic               flush;
  logic               seed_exit;
  logic               push_hs;
  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W-1:0]  fifo_head;

  assign gen_ready = (state == RUN) && !fifo_full;
  assign push_hs   = gen_valid && gen_ready;
  assign flush     = (state == RUN) && cfg_seed_load;
  assign seed_exit = (state == SEED) && gen_seed_ack && !cfg_seed_load;
  assign grant_go  = (state == RUN) && !fifo_empty && win_found && !flush;
  assign next_ptr  = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  rng_word_fifo #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (fifo_push),
    .pop   (grant_go),
    .flush (flush),
    .din   (gen_data),
    .head  (fifo_head),
    .level (buf_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef RNG_HEALTH_EN
  logic [DATA_W-1:0] last_word;
  logic              have_last;
  logic              health_r;
  logic              rep_hit;

  // A repeated word still completes the handshake but never reaches the FIFO.
  assign rep_hit     = have_last && (gen_data == last_word);
  assign fifo_push   = push_hs && !rep_hit;
  assign health_fail = health_r;

  // Repetition tracker: comparison restarts after each completed seed handshake.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      last_word <= '0;
      have_last <= 1'b0;
      health_r  <= 1'b0;
    end else if (seed_exit) begin
      have_last <= 1'b0;
      health_r  <= 1'b0;
    end else if (push_hs) begin
      if (rep_hit) begin
        health_r <= 1'b1;
      end else begin
        last_word <= gen_data;
        have_last <= 1'b1;
      end
    end
  end
`else
  assign fifo_push   = push_hs;
  assign health_fail = 1'b0;
`endif

  // Round-robin search: first asserted request at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Control FSM with registered seed handshake, status and grant outputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state          <= IDLE;
      busy           <= 1'b0;
      gen_seed_valid <= 1'b0;
      gen_seed       <= '0;
      gnt            <= '0;
      gnt_data       <= '0;
      rr_ptr         <= '0;
    end else begin
      if (cfg_seed_load) gen_seed <= cfg_seed;

      gnt <= '0;
      if (grant_go) begin
        gnt      <= NUM_REQ'(1) << win_idx;
        gnt_data <= fifo_head;
        rr_ptr   <= next_ptr;
      end

      case (state)
        IDLE: begin
          if (cfg_seed_load) begin
            state          <= SEED;
            busy           <= 1'b1;
            gen_seed_valid <= 1'b1;
          end else if (cfg_enable) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        SEED: begin
          if (seed_exit) begin
            gen_seed_valid <= 1'b0;
            if (cfg_enable) begin
              state <= RUN;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (cfg_seed_load) begin
            state          <= SEED;
            gen_seed_valid <= 1'b1;
          end else if (!cfg_enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          busy           <= 1'b0;
          gen_seed_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_sched.sv
// tb_rng_sched: directed scoreboard bench for rng_sched.
module tb_rng_sched;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 32;
  localparam int BUF_DEPTH = 4;
`ifdef RNG_HEALTH_EN
  localparam bit HEALTH = 1'b1;
`else
  localparam bit HEALTH = 1'b0;
`endif

  logic                ACLK = 1'b0;
  logic                ARESETN = 1'b0;
  logic                cfg_enable = 1'b0;
  logic                cfg_seed_load = 1'b0;
  logic [DATA_W-1:0]   cfg_seed = '0;
  logic                gen_seed_valid;
  logic [DATA_W-1:0]   gen_seed;
  logic                gen_seed_ack = 1'b0;
  logic                gen_valid = 1'b0;
  logic [DATA_W-1:0]   gen_data = '0;
  logic                gen_ready;
  logic [NUM_REQ-1:0]  req = '0;
  logic [NUM_REQ-1:0]  gnt;
  logic [DATA_W-1:0]   gnt_data;
  logic [$clog2(BUF_DEPTH):0] buf_level;
  logic                busy;
  logic                health_fail;

  typedef struct {
    logic [NUM_REQ-1:0] g;
    logic [DATA_W-1:0]  d;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  rng_sched #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .cfg_enable     (cfg_enable),
    .cfg_seed_load  (cfg_seed_load),
    .cfg_seed       (cfg_seed),
    .gen_seed_valid (gen_seed_valid),
    .gen_seed       (gen_seed),
    .gen_seed_ack   (gen_seed_ack),
    .gen_valid      (gen_valid),
    .gen_data       (gen_data),
    .gen_ready      (gen_ready),
    .req            (req),
    .gnt            (gnt),
    .gnt_data       (gnt_data),
    .buf_level      (buf_level),
    .busy           (busy),
    .health_fail    (health_fail)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic expect_gnt(input logic [NUM_REQ-1:0] g, input logic [DATA_W-1:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    sbq.push_back(e);
  endtask

  task automatic feed(input logic [DATA_W-1:0] w);
    gen_valid = 1'b1;
    gen_data  = w;
    step();
  endtask

  // Monitor: every grant the DUT presents must match the next scoreboard entry.
  always @(negedge ACLK) begin
    if (ARESETN && gnt != '0) begin
      if (sbq.size() == 0) begin
        check("gnt_unexpected", 32'(gnt), 32'h0);
      end else begin
        mon_e = sbq.pop_front();
        check("gnt_onehot", 32'(gnt), 32'(mon_e.g));
        check("gnt_data", gnt_data, mon_e.d);
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_gnt_data", gnt_data, 0);
    check("rst_level", 32'(buf_level), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_seed_valid", 32'(gen_seed_valid), 0);
    check("rst_seed", gen_seed, 0);
    check("rst_ready", 32'(gen_ready), 0);
    check("rst_health", 32'(health_fail), 0);
    ARESETN = 1'b1;
    step();

    // Seed handshake with ack held low for three cycles
    cfg_enable    = 1'b1;
    cfg_seed      = 32'hDEADBEEF;
    cfg_seed_load = 1'b1;
    step();
    cfg_seed_load = 1'b0;
    cfg_seed      = '0;
    for (int i = 0; i < 4; i++) begin
      check("seed_valid_hold", 32'(gen_seed_valid), 1);
      check("seed_value", gen_seed, 32'hDEADBEEF);
      check("seed_busy", 32'(busy), 1);
      if (i == 3) gen_seed_ack = 1'b1;
      step();
    end
    gen_seed_ack = 1'b0;
    check("seed_done_valid", 32'(gen_seed_valid), 0);
    check("run_busy", 32'(busy), 1);
    check("run_ready", 32'(gen_ready), 1);

    // Fill to full; word 5 must stay unconsumed
    for (int k = 1; k <= 4; k++) begin
      feed(32'(k));
      check("fill_level", 32'(buf_level), 32'(k));
    end
    gen_data = 32'd5;
    check("full_ready", 32'(gen_ready), 0);
    step();
    step();
    check("full_level_hold", 32'(buf_level), 4);
    check("full_ready_hold", 32'(gen_ready), 0);
    gen_valid = 1'b0;

    // Round robin across all four requesters
    expect_gnt(4'b0001, 32'd1);
    expect_gnt(4'b0010, 32'd2);
    expect_gnt(4'b0100, 32'd3);
    expect_gnt(4'b1000, 32'd4);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_level", 32'(buf_level), 32'(3 - k));
    end
    req = '0;
    step();
    check("rr_gnt_idle", 32'(gnt), 0);
    check("rr_data_hold", gnt_data, 32'd4);

    // Skip and wrap: pointer moved to 2, then req 0011 wraps to 0 then 1
    feed(32'h10);
    feed(32'h11);
    feed(32'h12);
    gen_valid = 1'b0;
    expect_gnt(4'b0010, 32'h10);
    req = 4'b0010;
    step();
    req = '0;
    check("skip_level", 32'(buf_level), 2);
    step();
    expect_gnt(4'b0001, 32'h11);
    expect_gnt(4'b0010, 32'h12);
    req = 4'b0011;
    step();
    step();
    req = '0;
    check("wrap_level", 32'(buf_level), 0);
    step();

    // Reseed in RUN flushes the buffer and suppresses the pending grant
    feed(32'h20);
    feed(32'h21);
    feed(32'h22);
    gen_valid = 1'b0;
    check("flush_pre_level", 32'(buf_level), 3);
    req           = 4'b0100;
    cfg_seed      = 32'h12345678;
    cfg_seed_load = 1'b1;
    step();
    cfg_seed_load = 1'b0;
    req           = '0;
    check("flush_level", 32'(buf_level), 0);
    check("flush_no_gnt", 32'(gnt), 0);
    check("flush_seed_valid", 32'(gen_seed_valid), 1);
    check("flush_seed", gen_seed, 32'h12345678);
    gen_seed_ack = 1'b1;
    step();
    gen_seed_ack = 1'b0;
    check("reseed_done", 32'(gen_seed_valid), 0);
    check("reseed_busy", 32'(busy), 1);

    // Disable: buffer retained, grants silent until re-enabled
    feed(32'h30);
    feed(32'h31);
    gen_valid  = 1'b0;
    cfg_enable = 1'b0;
    step();
    check("dis_busy", 32'(busy), 0);
    check("dis_level", 32'(buf_level), 2);
    check("dis_ready", 32'(gen_ready), 0);
    req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step();
      check("dis_no_gnt", 32'(gnt), 0);
    end
    check("dis_level_hold", 32'(buf_level), 2);
    expect_gnt(4'b0100, 32'h30);
    expect_gnt(4'b1000, 32'h31);
    cfg_enable = 1'b1;
    step();
    step();
    check("reen_level1", 32'(buf_level), 1);
    step();
    check("reen_level0", 32'(buf_level), 0);
    req = '0;
    step();
    check("reen_gnt_idle", 32'(gnt), 0);
    check("reen_data_hold", gnt_data, 32'h31);

    // Repetition test: 0x55, 0x55, 0x66 after a fresh seed
    cfg_seed      = 32'hA5A5A5A5;
    cfg_seed_load = 1'b1;
    step();
    cfg_seed_load = 1'b0;
    gen_seed_ack  = 1'b1;
    step();
    gen_seed_ack  = 1'b0;
    feed(32'h55);
    feed(32'h55);
    feed(32'h66);
    gen_valid = 1'b0;
    check("health_level", 32'(buf_level), HEALTH ? 32'd2 : 32'd3);
    check("health_flag", 32'(health_fail), 32'(HEALTH));
    expect_gnt(4'b0001, 32'h55);
    if (!HEALTH) expect_gnt(4'b0001, 32'h55);
    expect_gnt(4'b0001, 32'h66);
    req = 4'b0001;
    repeat (HEALTH ? 2 : 3) step();
    req = '0;
    step();
    check("health_drain", 32'(buf_level), 0);
    cfg_seed      = 32'h0BADF00D;
    cfg_seed_load = 1'b1;
    step();
    cfg_seed_load = 1'b0;
    check("health_sticky", 32'(health_fail), 32'(HEALTH));
    gen_seed_ack = 1'b1;
    step();
    gen_seed_ack = 1'b0;
    check("health_cleared", 32'(health_fail), 0);

    // Mid-handshake asynchronous reset
    cfg_seed      = 32'hCAFEF00D;
    cfg_seed_load = 1'b1;
    step();
    cfg_seed_load = 1'b0;
    cfg_enable    = 1'b0;
    check("mid_seed_valid", 32'(gen_seed_valid), 1);
    ARESETN = 1'b0;
    #1;
    check("arst_seed_valid", 32'(gen_seed_valid), 0);
    check("arst_seed", gen_seed, 0);
    check("arst_busy", 32'(busy), 0);
    step();
    ARESETN = 1'b1;
    step();
    step();
    check("post_rst_seed_valid", 32'(gen_seed_valid), 0);
    check("post_rst_busy", 32'(busy), 0);

    check("scoreboard_drain", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rng_sched.md
Name: rng_sched

Overview:
- Sequences the shared RNG generator core and distributes its 32-bit words to NUM_REQ on-chip consumers.
- Sits between the RNG AXI4-Lite register block and the generator core.
- Register block supplies enable, seed and seed-load.
- Block runs the seed-load handshake, prefetches words into a small buffer, and grants them round-robin to requesters.

Parameters:
- NUM_REQ, 4, number of requesting clients (>=2)
- DATA_W, 32, random word / seed width
- BUF_DEPTH, 4, prefetch buffer depth in words (power of 2, >=2)

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset
- cfg_enable  in  1  level; slv_reg0[0]; generation/grant enable
- cfg_seed_load  in  1  one-cycle pulse; load cfg_seed
- cfg_seed  in  DATA_W  seed value, sampled on cfg_seed_load
- gen_seed_valid  out  1  seed offered to generator
- gen_seed  out  DATA_W  latched seed
- gen_seed_ack  in  1  generator accepted seed
- gen_valid  in  1  generator word available
- gen_data  in  DATA_W  generator word
- gen_ready  out  1  block accepts word this cycle
- req  in  NUM_REQ  level request per client
- gnt  out  NUM_REQ  registered one-hot grant pulse
- gnt_data  out  DATA_W  word delivered with gnt
- buf_level  out  $clog2(BUF_DEPTH)+1  buffered word count
- busy  out  1  state != IDLE
- health_fail  out  1  sticky health flag (see Optional Feature)

Behaviour:
- Clock and reset: single clock ACLK; reset ARESETN, asynchronous assert, active-low.
- Reset values: all outputs 0; buffer empty; state IDLE; RR pointer 0 (req[0] highest priority).
- FSM states: IDLE, SEED, RUN.
- IDLE transitions:
  - cfg_seed_load -> SEED (priority over cfg_enable).
  - else cfg_enable -> RUN.
- RUN transitions:
  - cfg_seed_load -> SEED; buffer flushed same edge.
  - else !cfg_enable -> IDLE; buffer retained.
- SEED:
  - gen_seed_valid=1, gen_seed stable, until gen_seed_ack sampled high.
  - Then -> RUN if cfg_enable else IDLE.
  - A further cfg_seed_load in SEED overwrites gen_seed; handshake continues with the new value.
- Seed latch: on cfg_seed_load in any state, gen_seed <= cfg_seed.
- Fill:
  - gen_ready = (state==RUN) && (buf_level < BUF_DEPTH); combinational.
  - Push on gen_valid && gen_ready.
  - No push when full, even if a pop occurs the same cycle.
- Grant:
  - Evaluated only in RUN with buf_level > 0.
  - Choose the first asserted req at or after the RR pointer, wrapping NUM_REQ-1 -> 0.
  - Next edge: gnt=onehot(winner), gnt_data=buffer head, pop, pointer <= winner+1 mod NUM_REQ.
  - At most one grant per cycle.
  - Latency: req high with non-empty buffer -> gnt one cycle later.
- Consumer behaviour: a client that keeps req high receives repeated grants, interleaved fairly. A client must drop req in the cycle after gnt if it wants only one word.
- gnt_data holds its last value when gnt=0.
- Simultaneous push and pop in the same cycle: buf_level unchanged; FIFO order preserved.
- Flush in the same cycle as a pending grant: the grant is suppressed.
- buf_level reflects the post-edge count.
- Mid-operation reset: immediate return to reset values; no partial seed handshake retained.

Optional Feature:
- Macro RNG_HEALTH_EN.
- Defined:
  - Repetition test: a word equal to the previously pushed word is accepted (gen_ready handshake completes) but dropped.
  - health_fail is set and remains 1 until the next SEED exit.
  - The first word after seed or reset is never compared.
- Undefined:
  - No comparator or last-word register.
  - health_fail tied to 0.

Decomposition:
- Package rng_pkg:
  - state enum rng_sched_state_t {IDLE, SEED, RUN}.
  - Localparams RNG_DATA_W=32, RNG_NUM_REQ=4.
- One sub-module: rng_word_fifo.
  - Parameterised DATA_W/BUF_DEPTH synchronous FIFO.
  - Signals: push, pop, flush, head, level, full, empty.
- Arbiter and FSM stay in rng_sched.

Test Plan:
- Seed handshake: reset, cfg_seed=0xDEADBEEF + cfg_seed_load, hold gen_seed_ack low 3 cycles -> gen_seed_valid high 4 cycles, gen_seed=0xDEADBEEF, busy=1, then RUN with cfg_enable=1.
- Fill to full: RUN, gen_valid=1 with data 1,2,3,4,5, no req -> buf_level reaches 4, gen_ready=0, word 5 not consumed.
- Round-robin: buffer full of 1..4, req=4'b1111 held -> gnt 0001,0010,0100,1000 on consecutive cycles with gnt_data 1,2,3,4, buf_level 0.
- Skip and wrap: pointer at 2, req=4'b0011 -> gnt 0001 then 0010; with req[3] idle, grant order wraps correctly.
- Flush and disable: reseed in RUN with buf_level=3 -> buf_level 0 next cycle, no gnt. cfg_enable=0 in RUN -> IDLE, buffer retained, gnt silent.
- RNG_HEALTH_EN: words 0x55,0x55,0x66 -> buf_level 2 (0x55,0x66), health_fail=1; cleared after next seed handshake. Without macro -> buf_level 3, health_fail=0.
